// File: rtl/sha256_pkg.sv
// Shared SHA-256 types, constants and round functions.
// Used by sha256_round_ctrl and sha256_k_rom.
package sha256_pkg;

  typedef logic [31:0] word_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ROUND,
    ST_ADD,
    ST_DONE
  } state_t;

  localparam word_t IV [8] = '{
    32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
    32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
  };

  localparam word_t K_TABLE [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
    32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
    32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
    32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
    32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
    32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
    32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
    32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
    32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  function automatic word_t big_sigma0(input word_t x);
    return {x[1:0], x[31:2]} ^ {x[12:0], x[31:13]} ^ {x[21:0], x[31:22]};
  endfunction

  function automatic word_t big_sigma1(input word_t x);
    return {x[5:0], x[31:6]} ^ {x[10:0], x[31:11]} ^ {x[24:0], x[31:25]};
  endfunction

  function automatic word_t small_s0(input word_t x);
    return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ {3'b000, x[31:3]};
  endfunction

  function automatic word_t small_s1(input word_t x);
    return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ {10'b0, x[31:10]};
  endfunction

  function automatic word_t ch(input word_t e, input word_t f, input word_t g);
    return (e & f) ^ (~e & g);
  endfunction

  function automatic word_t maj(input word_t a, input word_t b, input word_t c);
    return (a & b) ^ (a & c) ^ (b & c);
  endfunction

endpackage

// File: rtl/sha256_k_rom.sv
// Combinational SHA-256 round-constant lookup, K[i_idx].
module sha256_k_rom
  import sha256_pkg::*;
(
  input  logic [5:0]  i_idx,
  output logic [31:0] o_k
);

  assign o_k = K_TABLE[i_idx];

endmodule

// File: rtl/sha256_round_ctrl.sv
// Iterative SHA-256 compression controller: one round per clock, final chaining add.
// Optional macro SHA256_CHAIN_EN adds i_blk_first for multi-block chaining.
module sha256_round_ctrl
  import sha256_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ROUNDS     = 64
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic                     i_in_valid,
  output logic                     o_in_ready,
  input  logic [16*DATA_WIDTH-1:0] i_blk_data,
`ifdef SHA256_CHAIN_EN
  input  logic                     i_blk_first,
`endif
  output logic                     o_out_valid,
  input  logic                     i_out_ready,
  output logic [8*DATA_WIDTH-1:0]  o_digest,
  output logic                     o_busy
);

  state_t r_state;
  state_t w_nextState;

  logic [5:0]   r_rnd;
  logic         r_addStage;
  logic         r_outValid;
  logic [255:0] r_digest;
  word_t        r_h  [8];
  word_t        r_wk [8];
  word_t        r_w  [16];

  word_t        w_k;
  word_t        w_t1;
  word_t        w_t2;
  word_t        w_wNew;
  word_t        w_initH [8];
  word_t        w_hSum  [8];
  logic [255:0] w_hPacked;
  logic         w_accept;

  sha256_k_rom u_k_rom (
    .i_idx (r_rnd),
    .o_k   (w_k)
  );

  assign w_accept    = (r_state == ST_IDLE) && i_in_valid;
  assign o_in_ready  = (r_state == ST_IDLE);
  assign o_busy      = (r_state == ST_ROUND) || (r_state == ST_ADD);
  assign o_out_valid = r_outValid;
  assign o_digest    = r_digest;

  assign w_t1 = r_wk[7] + big_sigma1(r_wk[4]) + ch(r_wk[4], r_wk[5], r_wk[6]) + w_k + r_w[0];
  assign w_t2 = big_sigma0(r_wk[0]) + maj(r_wk[0], r_wk[1], r_wk[2]);
  assign w_wNew = small_s1(r_w[14]) + r_w[9] + small_s0(r_w[1]) + r_w[0];

  always_comb begin
    w_hPacked = '0;
    for (int i = 0; i < 8; i++) begin
`ifdef SHA256_CHAIN_EN
      w_initH[i] = i_blk_first ? IV[i] : r_h[i];
`else
      w_initH[i] = IV[i];
`endif
      w_hSum[i] = r_h[i] + r_wk[i];
      w_hPacked[255-32*i -: 32] = r_h[i];
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_state <= ST_IDLE;
    else          r_state <= w_nextState;
  end

  always_comb begin
    w_nextState = r_state;
    case (r_state)
      ST_IDLE:  if (w_accept) w_nextState = ST_ROUND;
      ST_ROUND: if (r_rnd == 6'(ROUNDS - 1)) w_nextState = ST_ADD;
      ST_ADD:   if (r_addStage) w_nextState = ST_DONE;
      ST_DONE:  if (r_outValid && i_out_ready) w_nextState = ST_IDLE;
      default:  w_nextState = ST_IDLE;
    endcase
  end

  // ADD takes two cycles: chaining add into H, then publish H as the digest.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_rnd      <= '0;
      r_addStage <= 1'b0;
      r_outValid <= 1'b0;
      r_digest   <= '0;
      for (int i = 0; i < 8; i++) begin
        r_h[i]  <= IV[i];
        r_wk[i] <= '0;
      end
      for (int i = 0; i < 16; i++) r_w[i] <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_rnd <= '0;
            for (int i = 0; i < 16; i++) r_w[i] <= i_blk_data[511-32*i -: 32];
            for (int i = 0; i < 8; i++) begin
              r_wk[i] <= w_initH[i];
              r_h[i]  <= w_initH[i];
            end
          end
        end
        ST_ROUND: begin
          r_rnd <= r_rnd + 6'd1;
          for (int i = 0; i < 15; i++) r_w[i] <= r_w[i+1];
          r_w[15] <= w_wNew;
          r_wk[7] <= r_wk[6];
          r_wk[6] <= r_wk[5];
          r_wk[5] <= r_wk[4];
          r_wk[4] <= r_wk[3] + w_t1;
          r_wk[3] <= r_wk[2];
          r_wk[2] <= r_wk[1];
          r_wk[1] <= r_wk[0];
          r_wk[0] <= w_t1 + w_t2;
        end
        ST_ADD: begin
          if (!r_addStage) begin
            for (int i = 0; i < 8; i++) r_h[i] <= w_hSum[i];
            r_addStage <= 1'b1;
          end else begin
            r_digest   <= w_hPacked;
            r_outValid <= 1'b1;
            r_addStage <= 1'b0;
          end
        end
        ST_DONE: begin
          if (r_outValid && i_out_ready) r_outValid <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_sha256_round_ctrl.sv
// Self-checking bench for sha256_round_ctrl against a behavioural SHA-256 model.
// Define SHA256_CHAIN_EN to also exercise the two-block chaining path.
module tb_sha256_round_ctrl;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [511:0] blk_data = '0;
  logic         blk_first = 1'b1;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [255:0] digest;
  logic         busy;

  int checks = 0;
  int failures = 0;

  localparam logic [255:0] IV256 = {
    32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
    32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19};

  localparam logic [31:0] TK [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2};

  localparam logic [511:0] ABC_BLK   = {32'h61626380, 448'h0, 32'h00000018};
  localparam logic [511:0] EMPTY_BLK = {32'h80000000, 480'h0};
  localparam logic [255:0] ABC_DIG   =
    256'hba7816bf_8f01cfea_414140de_5dae2223_b00361a3_96177a9c_b410ff61_f20015ad;
  localparam logic [255:0] EMPTY_DIG =
    256'he3b0c442_98fc1c14_9afbf4c8_996fb924_27ae41e4_649b934c_a495991b_7852b855;

  always #5 clk = ~clk;

  sha256_round_ctrl dut (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .i_in_valid  (in_valid),
    .o_in_ready  (in_ready),
    .i_blk_data  (blk_data),
`ifdef SHA256_CHAIN_EN
    .i_blk_first (blk_first),
`endif
    .o_out_valid (out_valid),
    .i_out_ready (out_ready),
    .o_digest    (digest),
    .o_busy      (busy)
  );

  function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  // Textbook compression: full 64-word expansion, then 64 rounds, then chaining add.
  function automatic logic [255:0] ref_compress(input logic [255:0] hin, input logic [511:0] blk);
    logic [31:0] w [64];
    logic [31:0] v [8];
    logic [31:0] t1, t2, s0, s1;
    logic [255:0] res;
    for (int t = 0; t < 16; t++) w[t] = blk[511-32*t -: 32];
    for (int t = 16; t < 64; t++) begin
      s0 = rotr(w[t-15], 7) ^ rotr(w[t-15], 18) ^ (w[t-15] >> 3);
      s1 = rotr(w[t-2], 17) ^ rotr(w[t-2], 19) ^ (w[t-2] >> 10);
      w[t] = s1 + w[t-7] + s0 + w[t-16];
    end
    for (int i = 0; i < 8; i++) v[i] = hin[255-32*i -: 32];
    for (int t = 0; t < 64; t++) begin
      t1 = v[7] + (rotr(v[4], 6) ^ rotr(v[4], 11) ^ rotr(v[4], 25))
           + ((v[4] & v[5]) ^ (~v[4] & v[6])) + TK[t] + w[t];
      t2 = (rotr(v[0], 2) ^ rotr(v[0], 13) ^ rotr(v[0], 22))
           + ((v[0] & v[1]) ^ (v[0] & v[2]) ^ (v[1] & v[2]));
      for (int i = 7; i > 0; i--) v[i] = v[i-1];
      v[4] = v[4] + t1;
      v[0] = t1 + t2;
    end
    res = '0;
    for (int i = 0; i < 8; i++) res[255-32*i -: 32] = hin[255-32*i -: 32] + v[i];
    return res;
  endfunction

  function automatic logic [511:0] rand_block();
    logic [511:0] b;
    for (int i = 0; i < 16; i++) b[32*i +: 32] = $urandom;
    return b;
  endfunction

  // Offer a block and return once the accepting edge has passed (#1 after it).
  task automatic accept_block(input logic [511:0] blk, input logic first, output bit ok);
    ok = 1'b0;
    @(negedge clk);
    blk_data  = blk;
    blk_first = first;
    in_valid  = 1'b1;
    for (int n = 0; n < 200; n++) begin
      if (in_ready === 1'b1) begin
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    in_valid = 1'b0;
  endtask

  task automatic wait_digest(input int startN, output logic [255:0] dig, output int lat,
                             output bit busyOk);
    lat = -1;
    busyOk = 1'b1;
    for (int n = startN + 1; n <= 200; n++) begin
      @(posedge clk);
      #1;
      if (out_valid === 1'b1) begin
        lat = n;
        break;
      end
      if (busy !== 1'b1 || in_ready !== 1'b0) busyOk = 1'b0;
    end
    dig = digest;
  endtask

  task automatic finish_handshake();
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #12;
    checks++; if (in_ready !== 1'b1) begin failures++; $display("[TB] FAIL reset_in_ready got=%b exp=1", in_ready); end
    checks++; if (out_valid !== 1'b0) begin failures++; $display("[TB] FAIL reset_out_valid got=%b exp=0", out_valid); end
    checks++; if (busy !== 1'b0) begin failures++; $display("[TB] FAIL reset_busy got=%b exp=0", busy); end
    checks++; if (digest !== 256'h0) begin failures++; $display("[TB] FAIL reset_digest got=%h exp=0", digest); end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_abc();
    bit ok, busyOk;
    logic [255:0] dig;
    int lat;
    accept_block(ABC_BLK, 1'b1, ok);
    wait_digest(0, dig, lat, busyOk);
    checks++; if (!ok) begin failures++; $display("[TB] FAIL abc_accept got=0 exp=1"); end
    checks++; if (lat != 66) begin failures++; $display("[TB] FAIL abc_latency got=%0d exp=66", lat); end
    checks++; if (dig !== ABC_DIG) begin failures++; $display("[TB] FAIL abc_digest got=%h exp=%h", dig, ABC_DIG); end
    checks++; if (dig !== ref_compress(IV256, ABC_BLK)) begin failures++; $display("[TB] FAIL abc_model got=%h", dig); end
    checks++; if (!busyOk) begin failures++; $display("[TB] FAIL abc_busy_during_rounds got=0 exp=1"); end
    finish_handshake();
    checks++; if (out_valid !== 1'b0) begin failures++; $display("[TB] FAIL abc_valid_drop got=%b exp=0", out_valid); end
    checks++; if (in_ready !== 1'b1) begin failures++; $display("[TB] FAIL abc_idle_after got=%b exp=1", in_ready); end
  endtask

  task automatic test_empty();
    bit ok, busyOk;
    logic [255:0] dig;
    int lat;
    accept_block(EMPTY_BLK, 1'b1, ok);
    wait_digest(0, dig, lat, busyOk);
    checks++; if (dig !== EMPTY_DIG) begin failures++; $display("[TB] FAIL empty_digest got=%h exp=%h", dig, EMPTY_DIG); end
    checks++; if (lat != 66) begin failures++; $display("[TB] FAIL empty_latency got=%0d exp=66", lat); end
    finish_handshake();
  endtask

  task automatic test_random();
    bit ok, busyOk;
    logic [255:0] dig, expDig;
    logic [511:0] blk;
    int lat;
    for (int k = 0; k < 6; k++) begin
      blk = rand_block();
      expDig = ref_compress(IV256, blk);
      accept_block(blk, 1'b1, ok);
      wait_digest(0, dig, lat, busyOk);
      checks++;
      if (dig !== expDig || lat != 66) begin
        failures++;
        $display("[TB] FAIL random_%0d got=%h lat=%0d exp=%h lat=66", k, dig, lat, expDig);
      end
      finish_handshake();
    end
  endtask

  task automatic test_backpressure();
    bit ok, busyOk;
    logic [255:0] dig;
    int lat;
    accept_block(ABC_BLK, 1'b1, ok);
    wait_digest(0, dig, lat, busyOk);
    for (int c = 0; c < 10; c++) begin
      @(posedge clk);
      #1;
      checks++;
      if (out_valid !== 1'b1 || digest !== ABC_DIG || in_ready !== 1'b0) begin
        failures++;
        $display("[TB] FAIL backpressure_hold_%0d valid=%b ready=%b dig=%h exp valid=1 ready=0 dig=%h",
                 c, out_valid, in_ready, digest, ABC_DIG);
      end
    end
    finish_handshake();
    checks++; if (out_valid !== 1'b0) begin failures++; $display("[TB] FAIL backpressure_release got=%b exp=0", out_valid); end
    checks++; if (in_ready !== 1'b1) begin failures++; $display("[TB] FAIL backpressure_idle got=%b exp=1", in_ready); end
  endtask

  task automatic test_ready_early();
    bit ok, busyOk;
    logic [255:0] dig;
    int lat;
    out_ready = 1'b1;
    accept_block(EMPTY_BLK, 1'b1, ok);
    wait_digest(0, dig, lat, busyOk);
    checks++; if (dig !== EMPTY_DIG) begin failures++; $display("[TB] FAIL early_ready_digest got=%h exp=%h", dig, EMPTY_DIG); end
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      failures++;
      $display("[TB] FAIL early_ready_handshake valid=%b ready=%b exp valid=0 ready=1", out_valid, in_ready);
    end
  endtask

  task automatic test_reset_mid();
    bit ok, busyOk;
    logic [255:0] dig;
    int lat;
    accept_block(EMPTY_BLK, 1'b1, ok);
    repeat (30) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b0) begin failures++; $display("[TB] FAIL midreset_valid got=%b exp=0", out_valid); end
    checks++; if (in_ready !== 1'b1) begin failures++; $display("[TB] FAIL midreset_in_ready got=%b exp=1", in_ready); end
    checks++; if (busy !== 1'b0) begin failures++; $display("[TB] FAIL midreset_busy got=%b exp=0", busy); end
    @(negedge clk);
    rst_n = 1'b1;
    accept_block(ABC_BLK, 1'b1, ok);
    wait_digest(0, dig, lat, busyOk);
    checks++; if (dig !== ABC_DIG) begin failures++; $display("[TB] FAIL midreset_abc got=%h exp=%h", dig, ABC_DIG); end
    finish_handshake();
  endtask

  task automatic test_in_valid_ignored();
    bit ok, busyOk;
    logic [255:0] dig, expDig;
    logic [511:0] blk;
    int lat;
    blk = rand_block();
    expDig = ref_compress(IV256, blk);
    accept_block(blk, 1'b1, ok);
    for (int c = 0; c < 40; c++) begin
      @(posedge clk);
      #1;
      in_valid  = 1'($urandom_range(0, 1));
      blk_data  = rand_block();
      blk_first = 1'($urandom_range(0, 1));
    end
    wait_digest(40, dig, lat, busyOk);
    in_valid  = 1'b0;
    blk_first = 1'b1;
    checks++; if (dig !== expDig) begin failures++; $display("[TB] FAIL ignore_garbage got=%h exp=%h", dig, expDig); end
    checks++; if (lat != 66) begin failures++; $display("[TB] FAIL ignore_latency got=%0d exp=66", lat); end
    finish_handshake();
  endtask

`ifdef SHA256_CHAIN_EN
  task automatic test_chain();
    bit ok, busyOk;
    logic [255:0] dig1, dig2;
    logic [511:0] b1, b2;
    int lat;
    b1 = {32'h61626364, 32'h62636465, 32'h63646566, 32'h64656667,
          32'h65666768, 32'h66676869, 32'h6768696a, 32'h68696a6b,
          32'h696a6b6c, 32'h6a6b6c6d, 32'h6b6c6d6e, 32'h6c6d6e6f,
          32'h6d6e6f70, 32'h6e6f7071, 32'h80000000, 32'h00000000};
    b2 = {480'h0, 32'h000001c0};
    accept_block(b1, 1'b1, ok);
    wait_digest(0, dig1, lat, busyOk);
    finish_handshake();
    checks++; if (dig1 !== ref_compress(IV256, b1)) begin failures++; $display("[TB] FAIL chain_block1 got=%h", dig1); end
    accept_block(b2, 1'b0, ok);
    wait_digest(0, dig2, lat, busyOk);
    finish_handshake();
    checks++;
    if (dig2 !== 256'h248d6a61_d20638b8_e5c02693_0c3e6039_a33ce459_64ff2167_f6ecedd4_19db06c1) begin
      failures++;
      $display("[TB] FAIL chain_block2 got=%h exp=248d6a61d20638b8e5c026930c3e6039a33ce45964ff2167f6ecedd419db06c1", dig2);
    end
    checks++; if (dig2 !== ref_compress(dig1, b2)) begin failures++; $display("[TB] FAIL chain_model got=%h", dig2); end
    accept_block(ABC_BLK, 1'b1, ok);
    wait_digest(0, dig1, lat, busyOk);
    finish_handshake();
    checks++; if (dig1 !== ABC_DIG) begin failures++; $display("[TB] FAIL chain_restart got=%h exp=%h", dig1, ABC_DIG); end
  endtask
`endif

  initial begin
    test_reset();
    test_abc();
    test_empty();
    test_random();
    test_backpressure();
    test_ready_early();
    test_reset_mid();
    test_in_valid_ignored();
`ifdef SHA256_CHAIN_EN
    test_chain();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sha256_round_ctrl.md
Name: sha256_round_ctrl

Overview:
- Iterative SHA-256 compression engine controller: accepts one padded 512-bit block and runs 64 rounds, one round per clock.
- Sequences the round datapath (Sigma_0/Sigma_1/Ch/Maj adders) and drives the 16-word sliding message schedule and K-constant lookup.
- Performs the final chaining add and presents a 256-bit digest with valid/ready handshakes on both sides.
- Sits between the block padder/feeder and the digest consumer.

Parameters:
DATA_WIDTH, 32, word width; only 32 is supported.
ROUNDS, 64, number of compression rounds; fixed by the standard and not intended for override.

Ports:
clk  input  1  single clock, rising edge
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  blk_data is valid
in_ready  output  1  controller can accept a block
blk_data  input  512  padded block; W0 = [511:480] … W15 = [31:0]
out_valid  output  1  digest is valid
out_ready  input  1  consumer accepts the digest
digest  output  256  H0 = [255:224] … H7 = [31:0]
busy  output  1  high in ROUND or ADD

Behaviour:
- Reset, asynchronous on rst_n low:
  - state = IDLE, round counter = 0.
  - H registers = SHA-256 IV; a..h registers = 0.
  - out_valid = 0, digest = 0, busy = 0, in_ready = 1 (decoded from IDLE).
  - Reset asserted mid-operation aborts the block with no output.
- States: IDLE, ROUND, ADD, DONE.
- IDLE:
  - in_ready = 1.
  - On in_valid & in_ready: load W window from blk_data; load a..h from H; rnd = 0; go to ROUND.
- ROUND:
  - Each cycle computes T1 = h + Sigma_1(e) + Ch(e,f,g) + K[rnd] + W[rnd], and T2 = Sigma_0(a) + Maj(a,b,c).
  - State update: h=g, g=f, f=e, e=d+T1, d=c, c=b, b=a, a=T1+T2.
  - W window shifts each cycle. The new word is s1(W[t-2]) + W[t-7] + s0(W[t-15]) + W[t-16] (small sigma functions). The schedule is computed every round; the window contents are don't-care after round 63.
  - rnd increments 0..63. At rnd == 63, go to ADD.
- ADD:
  - H[i] = H[i] + {a..h}[i].
  - digest takes the new H; out_valid = 1; go to DONE.
- DONE:
  - out_valid held and digest stable until out_valid & out_ready, then back to IDLE.
  - in_ready = 0 and in_valid is ignored.
- Latency: out_valid rises on the 66th rising edge after the accepting edge (64 ROUND + ADD + entry to DONE).
- Throughput: one block per 66 cycles plus the out handshake cycle.
- Arithmetic: all additions are modulo 2^32; carries are discarded.
- H persists across blocks only if SHA256_CHAIN_EN is defined. Otherwise H reloads the IV when a block is accepted.
- Boundary cases:
  - in_valid asserted during ROUND/ADD/DONE: no effect; the input must be held by the source.
  - out_ready held high before out_valid: the handshake completes on the first DONE cycle.

Optional Feature:
- Macro: SHA256_CHAIN_EN.
- When defined:
  - Adds input port blk_first (1 bit), sampled with the in handshake.
  - blk_first = 1: H is loaded with the IV before the rounds.
  - blk_first = 0: the previous digest is used as the chaining value, enabling multi-block messages.
- When undefined:
  - No blk_first port.
  - Every accepted block starts from the IV, giving single-block hashing only.

Decomposition:
- Shared package sha256_pkg holds:
  - Word typedef (32-bit).
  - IV constant array (8 words).
  - K constant array (64 words).
  - State enum.
  - Functions: big Sigma_0, big Sigma_1, small s0, small s1, Ch, Maj.
- One natural sub-module, sha256_k_rom: combinational lookup of K[rnd] from a 6-bit index.

Test Plan:
- "abc" block (W0 = 61626380, W1..W14 = 0, W15 = 00000018) -> digest ba7816bf 8f01cfea 414140de 5dae2223 b00361a3 96177a9c b410ff61 f20015ad; out_valid exactly 66 edges after accept.
- Empty-message block (W0 = 80000000, rest 0) -> digest e3b0c442 98fc1c14 9afbf4c8 996fb924 27ae41e4 649b934c a495991b 7852b855.
- Backpressure: out_ready low for 10 cycles -> digest and out_valid stable, in_ready = 0 throughout; accept completes the cycle out_ready rises; IDLE next cycle.
- Reset mid-operation: rst_n pulsed low at round 30 -> out_valid = 0 immediately, in_ready = 1; then "abc" block -> correct digest (no stale state).
- in_valid toggled during ROUND with garbage data -> ignored; digest of the original block is unchanged.
- With SHA256_CHAIN_EN: two-block "abcdbcdecdefdefgefghfghighijhijkijkljklmklmnlmnomnopnopq" (blk_first = 1, then 0) -> 248d6a61 d20638b8 e5c02693 0c3e6039 a33ce459 64ff2167 f6ecedd4 19db06c1.
